// File: rtl/muldiv_hilo.sv
// muldiv_hilo: execute-stage multiply/divide unit owning the architectural HI/LO.
//   MULT/MULTU/DIV/DIVU run iteratively: 32 iterations, then a sign-fix cycle.
//   MTHI/MTLO write HI/LO in a single cycle.
//   Optional macro MULDIV_FAST_MULT_EN: MULT/MULTU use a single-cycle array product.
// Ports:
//   i_clk, i_nrst       clock, asynchronous active-low reset
//   i_con_start         op valid this cycle
//   i_con_op            000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   i_data_a, i_data_b  rs / rt operands
//   i_con_flush         cancel any in-flight op
//   o_data_hi/lo        architectural HI/LO
//   o_busy              iterative op in flight
//   o_divzero           one-cycle pulse on an accepted divide by zero
module muldiv_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_con_start,
  input  logic [2:0]       i_con_op,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic             i_con_flush,
  output logic [WIDTH-1:0] o_data_hi,
  output logic [WIDTH-1:0] o_data_lo,
  output logic             o_busy,
  output logic             o_divzero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;
  localparam int unsigned CW    = $clog2(WIDTH);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_divzero;

  logic               w_op_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_fix_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign o_data_hi = r_hi;
  assign o_data_lo = r_lo;
  assign o_busy    = (r_state != S_IDLE);
  assign o_divzero = r_divzero;

  // MULT (000) and DIV (010) are the signed ops
  assign w_op_signed = ~i_con_op[2] & ~i_con_op[0];
  assign w_sa        = w_op_signed & i_data_a[WIDTH-1];
  assign w_sb        = w_op_signed & i_data_b[WIDTH-1];
  assign w_abs_a     = w_sa ? ('0 - i_data_a) : i_data_a;
  assign w_abs_b     = w_sb ? ('0 - i_data_b) : i_data_b;

  // Multiply: acc = {partial product, remaining multiplier bits}; add on LSB, shift right
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}; quotient bits enter at the LSB
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
  assign w_div_next  = w_div_diff[WIDTH+1] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                           : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  always_comb begin
    w_fix_prod = r_neg_q ? ('0 - r_acc) : r_acc;
    w_fix_hi   = w_fix_prod[2*WIDTH-1:WIDTH];
    w_fix_lo   = w_fix_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_lo = r_neg_q ? ('0 - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      w_fix_hi = r_neg_r ? ('0 - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    end
  end

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] w_fast_mag;
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_mag  = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
  assign w_fast_prod = (w_sa ^ w_sb) ? ('0 - w_fast_mag) : w_fast_mag;
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_div  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_divzero <= 1'b0;
    end else begin
      r_divzero <= 1'b0;
      if (i_con_flush) begin
        // Flush beats a same-cycle accept and discards any pending result, including in FIX
        r_state <= S_IDLE;
        r_count <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_con_start) begin
              case (i_con_op)
                3'b000, 3'b001: begin
`ifdef MULDIV_FAST_MULT_EN
                  r_hi <= w_fast_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_fast_prod[WIDTH-1:0];
`else
                  r_state  <= S_MUL;
                  r_count  <= '0;
                  r_acc    <= {{WIDTH{1'b0}}, w_abs_b};
                  r_opnd   <= w_abs_a;
                  r_neg_q  <= w_sa ^ w_sb;
                  r_neg_r  <= 1'b0;
                  r_is_div <= 1'b0;
`endif
                end
                3'b010, 3'b011: begin
                  if (i_data_b == '0) begin
                    r_hi      <= i_data_a;
                    r_lo      <= '1;
                    r_divzero <= 1'b1;
                  end else begin
                    r_state  <= S_DIV;
                    r_count  <= '0;
                    r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                    r_opnd   <= w_abs_b;
                    r_neg_q  <= w_sa ^ w_sb;
                    r_neg_r  <= w_sa;
                    r_is_div <= 1'b1;
                  end
                end
                3'b100:  r_hi <= i_data_a;
                3'b101:  r_lo <= i_data_a;
                default: ;
              endcase
            end
          end
          S_MUL, S_DIV: begin
            r_acc   <= (r_state == S_MUL) ? w_mul_next : w_div_next;
            r_count <= r_count + CW'(1);
            if (r_count == CW'(WIDTH - 1)) r_state <= S_FIX;
          end
          default: begin
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        divzero;

  int checks;
  int errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] sb_q[$];

  muldiv_hilo #(.WIDTH(32)) dut (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_con_start(start),
    .i_con_op   (op),
    .i_data_a   (a),
    .i_data_b   (b),
    .i_con_flush(flush),
    .o_data_hi  (hi),
    .o_data_lo  (lo),
    .o_busy     (busy),
    .o_divzero  (divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb, input logic [31:0] ohi,
                                        input logic [31:0] olo);
    longint      sa;
    longint      sbv;
    longint      sq;
    longint      sr;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] t;
    logic [63:0] t2;
    sa  = longint'($signed(ma));
    sbv = longint'($signed(mb));
    ua  = {32'b0, ma};
    ub  = {32'b0, mb};
    case (mop)
      3'b000: t = 64'(sa * sbv);
      3'b001: t = ua * ub;
      3'b010: begin
        if (mb == 32'b0) t = {ma, 32'hFFFF_FFFF};
        else begin
          sq = sa / sbv;
          sr = sa % sbv;
          t  = 64'(sq);
          t2 = 64'(sr);
          t  = {t2[31:0], t[31:0]};
        end
      end
      3'b011: begin
        if (mb == 32'b0) t = {ma, 32'hFFFF_FFFF};
        else begin
          t  = ua / ub;
          t2 = ua % ub;
          t  = {t2[31:0], t[31:0]};
        end
      end
      3'b100:  t = {ma, olo};
      3'b101:  t = {ohi, ma};
      default: t = {ohi, olo};
    endcase
    return t;
  endfunction

  // Issue one op, follow it to completion, check latency, hold and scoreboard result
  task automatic run_op(input logic [2:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                        input string name);
    logic [63:0] exp;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          lat;
    int          cyc;
    logic        exp_dz;
    exp_dz = (rop[2:1] == 2'b01) && (rb == 32'b0);
    lat = (rop[2] || exp_dz) ? 0 : 33;
`ifdef MULDIV_FAST_MULT_EN
    if (rop[2:1] == 2'b00) lat = 0;
`endif
    sb_q.push_back(model(rop, ra, rb, m_hi, m_lo));
    old_hi = m_hi;
    old_lo = m_lo;
    @(negedge clk);
    start = 1'b1; op = rop; a = ra; b = rb;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (divzero !== exp_dz) begin
      errors++;
      $display("FAIL %s divzero got %b exp %b", name, divzero, exp_dz);
    end
    cyc = 0;
    while (busy && cyc < 100) begin
      checks++;
      if (hi !== old_hi || lo !== old_lo) begin
        errors++;
        $display("FAIL %s hold cyc %0d got %h_%h exp %h_%h", name, cyc, hi, lo, old_hi, old_lo);
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != lat) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d", name, cyc, lat);
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (hi !== exp[63:32] || lo !== exp[31:0]) begin
        errors++;
        $display("FAIL %s result got %h_%h exp %h_%h", name, hi, lo, exp[63:32], exp[31:0]);
      end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
    if (exp_dz) begin
      @(posedge clk); #1;
      checks++;
      if (divzero !== 1'b0) begin
        errors++;
        $display("FAIL %s divzero_pulse got %b exp 0", name, divzero);
      end
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b111; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo got %h_%h exp 0_0", hi, lo);
    end
    checks++;
    if (busy !== 1'b0 || divzero !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy %b dz %b exp 0 0", busy, divzero);
    end
    @(negedge clk);
    nrst = 1'b1;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_mul;
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_max_const got %h_%h exp fffffffe_00000001", hi, lo);
    end
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_neg_const got %h_%h exp ffffffff_fffffff1", hi, lo);
    end
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    run_op(3'b000, 32'd6, 32'd7, "mult_6x7");
  endtask

  task automatic test_div;
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, "div_neg7");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg7_const got %h_%h exp ffffffff_fffffffd", hi, lo);
    end
    run_op(3'b011, 32'd100, 32'd7, "divu_100_7");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checks++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_ovf_const got %h_%h exp 00000000_80000000", hi, lo);
    end
    run_op(3'b010, 32'd7, 32'hFFFF_FFFE, "div_pos_neg");
    run_op(3'b011, 32'hFFFF_FFFF, 32'd1, "divu_by1");
  endtask

  task automatic test_divzero;
    run_op(3'b011, 32'h55, 32'h0, "divu_zero");
    run_op(3'b010, 32'hFFFF_FF00, 32'h0, "div_zero");
  endtask

  task automatic test_flush;
    run_op(3'b100, 32'h1234, 32'h0, "mthi");
    run_op(3'b101, 32'hCAFE, 32'h0, "mtlo");
    run_op(3'b110, 32'hDEAD, 32'h0, "noop");
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'd10; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hBAD0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL start_in_busy got busy %b %h_%h exp 1 %h_%h", busy, hi, lo, m_hi, m_lo);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h1234 || lo !== m_lo) begin
      errors++;
      $display("FAIL flush_mid got busy %b %h_%h exp 0 00001234_%h", busy, hi, lo, m_lo);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL flush_after got busy %b %h_%h exp 0 %h_%h", busy, hi, lo, m_hi, m_lo);
    end
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b101; a = 32'h7777;
    @(posedge clk); #1;
    op = 3'b011; b = 32'd0;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || divzero !== 1'b0 || lo !== m_lo || hi !== m_hi) begin
      errors++;
      $display("FAIL flush_accept got busy %b dz %b %h_%h exp 0 0 %h_%h",
               busy, divzero, hi, lo, m_hi, m_lo);
    end
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd1000; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL flush_fix got busy %b %h_%h exp 0 %h_%h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_midop;
    run_op(3'b100, 32'h0BAD_BEEF, 32'h0, "mthi_pre");
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'h1234_5678; b = 32'hFFFF_0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop got busy %b %h_%h exp 0 0_0", busy, hi, lo);
    end
    @(negedge clk);
    nrst = 1'b1;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_back_to_back;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 2 == 1) ra = ra ^ 32'h8000_0000;
      run_op(rop, ra, rb, "b2b");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
